// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared types and constants for the sequential FP divider
package fdiv_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int ITER_N = 26;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;

  typedef enum logic [1:0] {FC_ZERO, FC_INF, FC_NAN, FC_NORMAL} fclass_t;

  // Denormals share the zero class: they are flushed on input.
  function automatic fclass_t classify(input logic [30:0] v);
    if (v[30:23] == 8'h00) return FC_ZERO;
    if (v[30:23] == 8'hFF) return (v[22:0] == 23'd0) ? FC_INF : FC_NAN;
    return FC_NORMAL;
  endfunction

endpackage

// File: rtl/fdiv_seq_if.sv
// rtl/fdiv_seq_if.sv - start/busy/done request-result bundle for fdiv_seq
interface fdiv_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        dz_flag;
  logic        nv_flag;

  modport master (output start, a, b, input busy, done, y, dz_flag, nv_flag);
  modport slave  (input start, a, b, output busy, done, y, dz_flag, nv_flag);
endinterface

// File: rtl/fdiv_classify.sv
// rtl/fdiv_classify.sv - combinational operand classifier for the divider
module fdiv_classify
  import fdiv_pkg::*;
(
  input  logic [30:0] i_a,
  input  logic [30:0] i_b,
  output fclass_t     o_cls_a,
  output fclass_t     o_cls_b
);

  assign o_cls_a = classify(i_a);
  assign o_cls_b = classify(i_b);

endmodule

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative single-precision divider, one quotient bit per clock
// FDIV_RNE_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module fdiv_seq
  import fdiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fdiv_seq_if.slave  bus
);

  state_t             r_state, w_next;
  logic               w_busy, w_done;
  logic [31:0]        r_a, r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic               r_spec, r_spec_dz, r_spec_nv;
  logic [31:0]        r_spec_y;
  logic [31:0]        r_y;
  logic               r_dz, r_nv;

  fclass_t            w_cls_a, w_cls_b;
  logic               w_sign, w_spec, w_spec_dz, w_spec_nv;
  logic [31:0]        w_spec_y;
  logic signed [9:0]  w_exp;
  logic [24:0]        w_diff;
  logic [22:0]        w_mant;
  logic signed [9:0]  w_exp_n, w_exp_r;
  logic               w_inc;
  logic [23:0]        w_mant_r;
  logic [31:0]        w_res;
`ifdef FDIV_RNE_EN
  logic               w_g, w_s;
`endif

  fdiv_classify u_classify (
    .i_a     (r_a[30:0]),
    .i_b     (r_b[30:0]),
    .o_cls_a (w_cls_a),
    .o_cls_b (w_cls_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = PREP;
      end
      PREP: w_next = ITER;
      ITER: if (r_cnt == 5'(ITER_N - 1)) w_next = NORM;
      NORM: w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Special operands still walk the full pipeline so latency never varies.
  always_comb begin
    w_sign    = r_a[31] ^ r_b[31];
    w_exp     = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'(BIAS);
    w_spec    = 1'b1;
    w_spec_y  = QNAN;
    w_spec_dz = 1'b0;
    w_spec_nv = 1'b0;
    if (w_cls_a == FC_NAN || w_cls_b == FC_NAN) begin
      w_spec_nv = 1'b1;
    end else if ((w_cls_a == FC_ZERO && w_cls_b == FC_ZERO) ||
                 (w_cls_a == FC_INF  && w_cls_b == FC_INF)) begin
      w_spec_nv = 1'b1;
    end else if (w_cls_a == FC_INF) begin
      w_spec_y = PINF | {w_sign, 31'd0};
    end else if (w_cls_b == FC_ZERO) begin
      w_spec_y  = PINF | {w_sign, 31'd0};
      w_spec_dz = 1'b1;
    end else if (w_cls_a == FC_ZERO || w_cls_b == FC_INF) begin
      w_spec_y = {w_sign, 31'd0};
    end else begin
      w_spec = 1'b0;
    end
  end

  assign w_diff = r_rem - {1'b0, r_mb};

  always_comb begin
    if (r_q[25]) begin
      w_mant  = r_q[24:2];
      w_exp_n = r_exp;
    end else begin
      w_mant  = r_q[23:1];
      w_exp_n = r_exp - 10'sd1;
    end
`ifdef FDIV_RNE_EN
    w_g   = r_q[25] ? r_q[1] : r_q[0];
    w_s   = (r_q[25] & r_q[0]) | (r_rem != 25'd0);
    w_inc = w_g & (w_s | w_mant[0]);
`else
    w_inc = 1'b0;
`endif
    w_mant_r = {1'b0, w_mant} + 24'(w_inc);
    w_exp_r  = w_exp_n + $signed({9'd0, w_mant_r[23]});
    if (r_spec)                     w_res = r_spec_y;
    else if (w_exp_r >= 10'sd255)   w_res = PINF | {r_sign, 31'd0};
    else if (w_exp_r <= 10'sd0)     w_res = {r_sign, 31'd0};
    else                            w_res = {r_sign, w_exp_r[7:0], w_mant_r[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_rem     <= '0;
      r_mb      <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_spec    <= 1'b0;
      r_spec_y  <= '0;
      r_spec_dz <= 1'b0;
      r_spec_nv <= 1'b0;
      r_y       <= '0;
      r_dz      <= 1'b0;
      r_nv      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.start) begin
          r_a  <= bus.a;
          r_b  <= bus.b;
          r_dz <= 1'b0;
          r_nv <= 1'b0;
        end
        PREP: begin
          r_sign    <= w_sign;
          r_exp     <= w_exp;
          r_rem     <= {2'b01, r_a[22:0]};
          r_mb      <= {1'b1, r_b[22:0]};
          r_q       <= '0;
          r_cnt     <= '0;
          r_spec    <= w_spec;
          r_spec_y  <= w_spec_y;
          r_spec_dz <= w_spec_dz;
          r_spec_nv <= w_spec_nv;
        end
        ITER: begin
          if (r_rem >= {1'b0, r_mb}) begin
            r_q   <= {r_q[24:0], 1'b1};
            r_rem <= {w_diff[23:0], 1'b0};
          end else begin
            r_q   <= {r_q[24:0], 1'b0};
            r_rem <= {r_rem[23:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          r_y  <= w_res;
          r_dz <= r_spec_dz;
          r_nv <= r_spec_nv;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.y       = r_y;
  assign bus.dz_flag = r_dz;
  assign bus.nv_flag = r_nv;

endmodule
